// File: rtl/program_loader_pkg.sv
// program_loader_pkg: loader state encoding, header width and default sizes.
package program_loader_pkg;
    localparam int INSTRUCTION_SIZE = 16;
    localparam int ADDRESS_SIZE = 10;
    localparam int HDR_WIDTH = 16;
    typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, WRITE, DONE, ERROR} state_t;
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: byte stream in, program memory write port and status out.
interface program_loader_if #(
    parameter int INSTR_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    logic                   in_valid;
    logic [7:0]             in_data;
    logic                   in_ready;
    logic                   load_request;
    logic                   pm_write_enable;
    logic [ADDR_WIDTH-1:0]  pm_address;
    logic [INSTR_WIDTH-1:0] pm_data;
    logic                   core_reset;
    logic                   done;
    logic                   error;
    modport master (
        output in_valid, in_data, load_request,
        input  in_ready, pm_write_enable, pm_address, pm_data, core_reset, done, error
    );
    modport slave (
        input  in_valid, in_data, load_request,
        output in_ready, pm_write_enable, pm_address, pm_data, core_reset, done, error
    );
endinterface

// File: rtl/program_loader_word_assembler.sv
// program_loader_word_assembler: shifts bytes in from the LSB side and flags the last byte of a word.
module program_loader_word_assembler #(
    parameter int BYTES_PER_WORD = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        shift,
    input  logic [7:0]                  byte_in,
    output logic [8*BYTES_PER_WORD-1:0] word_next,
    output logic                        word_complete
);
    localparam int W = 8 * BYTES_PER_WORD;
    localparam int CW = BYTES_PER_WORD > 1 ? $clog2(BYTES_PER_WORD) : 1;
    logic [W-1:0]  sr;
    logic [CW-1:0] cnt;
    // word_next already includes the byte being accepted, so the caller can register it directly
    assign word_next = W'({sr, byte_in});
    assign word_complete = shift && cnt == CW'(BYTES_PER_WORD - 1);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sr  <= '0;
            cnt <= '0;
        end else if (shift) begin
            sr  <= word_next;
            cnt <= word_complete ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: fills program memory from a counted byte stream and holds the core in reset until done.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int INSTR_WIDTH = INSTRUCTION_SIZE,
    parameter int ADDR_WIDTH = ADDRESS_SIZE
) (
    input logic             clock,
    input logic             reset,
    program_loader_if.slave bus
);
    localparam int BYTES_PER_WORD = INSTR_WIDTH / 8;
    localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;
    state_t                 state, next;
    logic [HDR_WIDTH-1:0]   count;
    logic [HDR_WIDTH-1:0]   hdr_full;
    logic [ADDR_WIDTH:0]    idx;
    logic                   xfer, last_word, word_complete;
    logic [INSTR_WIDTH-1:0] word_next;
    assign xfer = bus.in_valid && bus.in_ready;
    assign hdr_full = {count[HDR_WIDTH-1:8], bus.in_data};
    assign last_word = 32'(idx) + 32'd1 == 32'(count);
    program_loader_word_assembler #(.BYTES_PER_WORD(BYTES_PER_WORD)) asm_i (
        .clock(clock),
        .reset(reset),
        .shift(xfer && state == DATA),
        .byte_in(bus.in_data),
        .word_next(word_next),
        .word_complete(word_complete)
    );
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= HDR_HI;
        else state <= next;
    end
    always_comb begin
        next = state;
        case (state)
            HDR_HI: next = xfer ? HDR_LO : HDR_HI;
            HDR_LO: next = !xfer ? HDR_LO : hdr_full == '0 ? DONE : 32'(hdr_full) > DEPTH ? ERROR : DATA;
            DATA:   next = word_complete ? WRITE : DATA;
            WRITE:  next = last_word ? DONE : DATA;
            DONE,
            ERROR:  next = bus.load_request ? HDR_HI : state;
            default: next = HDR_HI;
        endcase
    end
    // in_ready is forced low while reset is held, even though state already reads HDR_HI
    always_comb begin
        bus.in_ready = reset && (state == HDR_HI || state == HDR_LO || state == DATA);
        bus.done = state == DONE;
        bus.error = state == ERROR;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.pm_write_enable <= 1'b0;
            bus.pm_address      <= '0;
            bus.pm_data         <= '0;
            bus.core_reset      <= 1'b0;
            idx                 <= '0;
            count               <= '0;
        end else begin
            bus.pm_write_enable <= next == WRITE;
            bus.core_reset      <= next == DONE;
            if (next == WRITE) begin
                bus.pm_address <= idx[ADDR_WIDTH-1:0];
                bus.pm_data    <= word_next;
            end
            if (state == WRITE) idx <= idx + 1'b1;
            else if ((state == DONE || state == ERROR) && bus.load_request) idx <= '0;
            if (state == HDR_HI && xfer) count[HDR_WIDTH-1:8] <= bus.in_data;
            if (state == HDR_LO && xfer) count[7:0] <= bus.in_data;
        end
    end
endmodule
